// File: rtl/block_word_access_pkg.sv
// -----------------------------------------------------------------------------
// block_word_access_pkg
// Shared definitions for the block word access slice:
//   state_e   : response FSM state encoding
//   widths_ok : elaboration-time consistency check of WORDS against OFFSET_W
// -----------------------------------------------------------------------------
package block_word_access_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // A line must hold at least two words, and the word index must address
    // exactly WORDS entries so that offset arithmetic wraps modulo WORDS.
    function automatic bit widths_ok(input int words, input int offset_w);
        bit ok_v;
        ok_v = (words >= 2) && ((32'd1 << offset_w) == words);
        return ok_v;
    endfunction

endpackage

// File: rtl/block_word_merge.sv
// -----------------------------------------------------------------------------
// block_word_merge
// Combinational byte merge of one word into a cache line.
//   line   : source line
//   offset : index of the word to update
//   word   : new word data
//   be     : byte enables, bit b selects byte b of the word
//   merged : line with the enabled bytes of word 'offset' replaced
// -----------------------------------------------------------------------------
module block_word_merge
    import block_word_access_pkg::*;
#(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int WORDS            = BLOCK_DATA_WIDTH / WORD_SIZE,
    parameter int OFFSET_W         = $clog2(WORDS),
    parameter int BE_W             = WORD_SIZE / 8
) (
    input  logic [BLOCK_DATA_WIDTH-1:0] line,
    input  logic [OFFSET_W-1:0]         offset,
    input  logic [WORD_SIZE-1:0]        word,
    input  logic [BE_W-1:0]             be,
    output logic [BLOCK_DATA_WIDTH-1:0] merged
);

    // Per-byte select: only bytes of the addressed word with their enable set change.
    always_comb begin
        merged = line;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < BE_W; b++) begin
                merged[w*WORD_SIZE + b*8 +: 8] =
                    ((offset == w[OFFSET_W-1:0]) && be[b]) ? word[b*8 +: 8]
                                                           : line[w*WORD_SIZE + b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/block_word_access.sv
// -----------------------------------------------------------------------------
// block_word_access
// Word-granular access to a cache line. A request is accepted in IDLE; the
// line is captured and the response beats follow from the captured copy.
//   Read : returns words offset, offset+1, ... (mod WORDS), critical word first.
//   Write: single beat; line_out = captured line with the word byte-merged,
//          rsp_rdata = the word before the merge.
// Ports: clk, rst_n (synchronous, active low), req_* request channel,
//        line_in source line, rsp_* response channel, line_out merged line.
// Configuration macro BLOCK_WORD_ACCESS_BURST_EN:
//   defined   -> multi-beat reads of req_len words, illegal lengths flagged
//                on rsp_err with a single zero beat.
//   undefined -> every read is a single beat, req_len ignored, rsp_err = 0.
// -----------------------------------------------------------------------------
module block_word_access
    import block_word_access_pkg::*;
#(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int WORDS            = BLOCK_DATA_WIDTH / WORD_SIZE,
    parameter int OFFSET_W         = $clog2(WORDS),
    parameter int BE_W             = WORD_SIZE / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [OFFSET_W-1:0]         req_offset,
    input  logic [OFFSET_W:0]           req_len,
    input  logic [WORD_SIZE-1:0]        req_wdata,
    input  logic [BE_W-1:0]             req_be,
    input  logic [BLOCK_DATA_WIDTH-1:0] line_in,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WORD_SIZE-1:0]        rsp_rdata,
    output logic                        rsp_last,
    output logic [BLOCK_DATA_WIDTH-1:0] line_out,
    output logic                        rsp_err
);

    if (!widths_ok(WORDS, OFFSET_W) || (BE_W * 8 != WORD_SIZE) ||
        (WORDS * WORD_SIZE != BLOCK_DATA_WIDTH)) begin : g_bad_cfg
        $error("block_word_access: inconsistent width parameters");
    end

    state_e                              state_r, state_nxt_s;
    logic                                ready_r;
    logic                                rsp_valid_r, valid_nxt_s;
    logic [WORD_SIZE-1:0]                rsp_rdata_r, rdata_nxt_s;
    logic                                rsp_last_r, last_nxt_s;
    logic                                rsp_err_r, err_nxt_s;
    logic [BLOCK_DATA_WIDTH-1:0]         line_out_r, line_out_nxt_s;
    logic [BLOCK_DATA_WIDTH-1:0]         merged_s;
    logic [WORDS-1:0][WORD_SIZE-1:0]     line_in_words_s;
    logic                                handshake_s;

    assign line_in_words_s = line_in;
    assign handshake_s     = rsp_valid_r && rsp_ready;

`ifdef BLOCK_WORD_ACCESS_BURST_EN
    localparam logic [OFFSET_W:0] LEN_ZERO = {(OFFSET_W+1){1'b0}};
    localparam logic [OFFSET_W:0] LEN_ONE  = {{OFFSET_W{1'b0}}, 1'b1};
    localparam logic [OFFSET_W:0] LEN_MAX  = (OFFSET_W+1)'(WORDS);

    logic [WORDS-1:0][WORD_SIZE-1:0]     line_words_r;
    logic [OFFSET_W-1:0]                 offset_r;
    logic [OFFSET_W:0]                   len_r;
    logic [OFFSET_W-1:0]                 beat_r, beat_nxt_s;
    logic [OFFSET_W-1:0]                 rd_idx_s;
    logic                                capture_s;
    logic                                len_bad_s;

    assign len_bad_s = (req_len == LEN_ZERO) || (req_len > LEN_MAX);
`else
    logic unused_len_s;
    assign unused_len_s = ^req_len;
`endif

    block_word_merge #(
        .WORD_SIZE        (WORD_SIZE),
        .BLOCK_DATA_WIDTH (BLOCK_DATA_WIDTH),
        .WORDS            (WORDS),
        .OFFSET_W         (OFFSET_W),
        .BE_W             (BE_W)
    ) u_merge (
        .line   (line_in),
        .offset (req_offset),
        .word   (req_wdata),
        .be     (req_be),
        .merged (merged_s)
    );

    // Next-state and next-output logic; outputs hold unless a transition occurs.
    always_comb begin
        state_nxt_s    = state_r;
        valid_nxt_s    = rsp_valid_r;
        rdata_nxt_s    = rsp_rdata_r;
        last_nxt_s     = rsp_last_r;
        err_nxt_s      = rsp_err_r;
        line_out_nxt_s = line_out_r;
`ifdef BLOCK_WORD_ACCESS_BURST_EN
        beat_nxt_s     = beat_r;
        rd_idx_s       = offset_r;
        capture_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_RESP;
                    valid_nxt_s = 1'b1;
`ifdef BLOCK_WORD_ACCESS_BURST_EN
                    capture_s   = 1'b1;
                    beat_nxt_s  = {OFFSET_W{1'b0}};
`endif
                    if (req_write) begin
                        rdata_nxt_s    = line_in_words_s[req_offset];
                        last_nxt_s     = 1'b1;
                        err_nxt_s      = 1'b0;
                        line_out_nxt_s = merged_s;
                    end else begin
`ifdef BLOCK_WORD_ACCESS_BURST_EN
                        if (len_bad_s) begin
                            rdata_nxt_s = {WORD_SIZE{1'b0}};
                            last_nxt_s  = 1'b1;
                            err_nxt_s   = 1'b1;
                        end else begin
                            rdata_nxt_s = line_in_words_s[req_offset];
                            last_nxt_s  = (req_len == LEN_ONE);
                            err_nxt_s   = 1'b0;
                        end
`else
                        rdata_nxt_s = line_in_words_s[req_offset];
                        last_nxt_s  = 1'b1;
                        err_nxt_s   = 1'b0;
`endif
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (handshake_s && rsp_last_r) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                    rdata_nxt_s = {WORD_SIZE{1'b0}};
                    last_nxt_s  = 1'b0;
                    err_nxt_s   = 1'b0;
                end else if (handshake_s) begin
`ifdef BLOCK_WORD_ACCESS_BURST_EN
                    // Offset plus beat wraps naturally in OFFSET_W bits (mod WORDS).
                    beat_nxt_s  = beat_r + {{(OFFSET_W-1){1'b0}}, 1'b1};
                    rd_idx_s    = offset_r + beat_nxt_s;
                    rdata_nxt_s = line_words_r[rd_idx_s];
                    last_nxt_s  = ({1'b0, beat_nxt_s} == (len_r - LEN_ONE));
`else
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                    rdata_nxt_s = {WORD_SIZE{1'b0}};
                    last_nxt_s  = 1'b0;
                    err_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
                rdata_nxt_s = {WORD_SIZE{1'b0}};
                last_nxt_s  = 1'b0;
                err_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and registered response outputs; reset dominates any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WORD_SIZE{1'b0}};
            rsp_last_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            line_out_r  <= {BLOCK_DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ready_r     <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= valid_nxt_s;
            rsp_rdata_r <= rdata_nxt_s;
            rsp_last_r  <= last_nxt_s;
            rsp_err_r   <= err_nxt_s;
            line_out_r  <= line_out_nxt_s;
        end
    end

`ifdef BLOCK_WORD_ACCESS_BURST_EN
    // Captured request context and beat counter for multi-beat reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_words_r <= {BLOCK_DATA_WIDTH{1'b0}};
            offset_r     <= {OFFSET_W{1'b0}};
            len_r        <= {(OFFSET_W+1){1'b0}};
            beat_r       <= {OFFSET_W{1'b0}};
        end else begin
            beat_r <= beat_nxt_s;
            if (capture_s) begin
                line_words_r <= line_in;
                offset_r     <= req_offset;
                len_r        <= req_len;
            end else begin
                line_words_r <= line_words_r;
                offset_r     <= offset_r;
                len_r        <= len_r;
            end
        end
    end
`endif

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_last  = rsp_last_r;
    assign rsp_err   = rsp_err_r;
    assign line_out  = line_out_r;

endmodule

// File: tb/tb_block_word_access.sv
// -----------------------------------------------------------------------------
// tb_block_word_access
// Scoreboard bench: each request pushes its expected beats, a negedge monitor
// compares every presented beat against the queue head (also while stalled)
// and pops it on handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_word_access;

    localparam int WS    = 32;
    localparam int BDW   = 512;
    localparam int WORDS = 16;
    localparam int OW    = 4;
    localparam int BEW   = 4;
`ifdef BLOCK_WORD_ACCESS_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [OW-1:0]  req_offset;
    logic [OW:0]    req_len;
    logic [WS-1:0]  req_wdata;
    logic [BEW-1:0] req_be;
    logic [BDW-1:0] line_in;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [WS-1:0]  rsp_rdata;
    logic           rsp_last;
    logic [BDW-1:0] line_out;
    logic           rsp_err;

    block_word_access #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_offset(req_offset), .req_len(req_len), .req_wdata(req_wdata),
        .req_be(req_be), .line_in(line_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .line_out(line_out), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [WS-1:0]  rdata;
        logic           last;
        logic           err;
        logic           is_wr;
        logic [BDW-1:0] line;
    } exp_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_errors = 0;
    logic [BDW-1:0] last_merged = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [BDW-1:0] obs, input logic [BDW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WS-1:0] word_of(input logic [BDW-1:0] l, input int i);
        return l[i*WS +: WS];
    endfunction

    // Byte-enable bit b replaces byte b (bits 8b+7..8b) of the addressed word.
    function automatic logic [BDW-1:0] merge_model(input logic [BDW-1:0] l, input int off,
                                                   input logic [WS-1:0] wd, input logic [BEW-1:0] be);
        logic [BDW-1:0] r;
        r = l;
        for (int b = 0; b < BEW; b++) begin
            if (be[b]) r[off*WS + b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [BDW-1:0] rand_line();
        logic [BDW-1:0] l;
        for (int i = 0; i < WORDS; i++) l[i*WS +: WS] = $urandom();
        return l;
    endfunction

    function automatic logic [BDW-1:0] ramp_line();
        logic [BDW-1:0] l;
        for (int i = 0; i < WORDS; i++) l[i*WS +: WS] = i;
        return l;
    endfunction

    // Push expected beats, then present the request for one accepting edge.
    task automatic issue(input logic wr, input int off, input int len, input logic [WS-1:0] wd,
                         input logic [BEW-1:0] be, input logic [BDW-1:0] line);
        exp_t e;
        int   g;
        int   n;
        g = 0;
        while (!req_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check_val("ready_wait", req_ready, 1'b1);
        e.is_wr = wr;
        e.line  = '0;
        if (wr) begin
            e.rdata = word_of(line, off);
            e.last  = 1'b1;
            e.err   = 1'b0;
            e.line  = merge_model(line, off, wd, be);
            last_merged = e.line;
            sb.push_back(e);
        end else if (BURST && (len < 1 || len > WORDS)) begin
            e.rdata = '0;
            e.last  = 1'b1;
            e.err   = 1'b1;
            sb.push_back(e);
        end else begin
            n = BURST ? len : 1;
            for (int k = 0; k < n; k++) begin
                e.rdata = word_of(line, (off + k) % WORDS);
                e.last  = (k == n - 1);
                e.err   = 1'b0;
                sb.push_back(e);
            end
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_offset = off[OW-1:0];
        req_len    = len[OW:0];
        req_wdata  = wd;
        req_be     = be;
        line_in    = line;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        line_in    = rand_line();
        check_val("latency_valid", rsp_valid, 1'b1);
        check_val("busy_ready", req_ready, 1'b0);
    endtask

    // Wait for all expected beats, then confirm the idle output state.
    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_val({tag, "_drain"}, sb.size(), 0);
        @(negedge clk);
        check_val({tag, "_idle_valid"}, rsp_valid, 1'b0);
        check_val({tag, "_idle_rdata"}, rsp_rdata, '0);
        check_val({tag, "_idle_last"}, rsp_last, 1'b0);
        check_val({tag, "_idle_err"}, rsp_err, 1'b0);
        check_val({tag, "_idle_ready"}, req_ready, 1'b1);
        sb.delete();
    endtask

    // Beat monitor: compare the presented beat with the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check_val("extra_beat", rsp_valid, 1'b0);
            end else begin
                check_val("rdata", rsp_rdata, sb[0].rdata);
                check_val("last", rsp_last, sb[0].last);
                check_val("err", rsp_err, sb[0].err);
                if (sb[0].is_wr) check_val("line_out", line_out, sb[0].line);
                if (rsp_ready) sb.delete(0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BDW-1:0] l;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_offset = '0; req_len = '0;
        req_wdata = '0; req_be = '0; line_in = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", req_ready, 1'b1);
        check_val("rst_valid", rsp_valid, 1'b0);
        check_val("rst_rdata", rsp_rdata, '0);
        check_val("rst_last", rsp_last, 1'b0);
        check_val("rst_err", rsp_err, 1'b0);
        check_val("rst_line", line_out, '0);

        // Single-word read.
        l = rand_line();
        l[3*WS +: WS] = 32'hDEADBEEF;
        issue(1'b0, 3, 1, '0, '0, l);
        drain("rd_single");

        // Wrapping burst, critical word first.
        issue(1'b0, 14, 4, '0, '0, ramp_line());
        drain("rd_wrap");

        // Back-pressure for 3 cycles on the second beat (first in single-beat builds).
        issue(1'b0, 5, 4, '0, '0, rand_line());
        if (BURST) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain("rd_stall");

        // Byte-merge write.
        l = rand_line();
        l[0 +: WS] = 32'h11223344;
        issue(1'b1, 0, 1, 32'hAABBCCDD, 4'b0101, l);
        drain("wr_merge");

        // Read leaves line_out untouched.
        issue(1'b0, 2, 1, '0, '0, rand_line());
        drain("rd_after_wr");
        check_val("line_hold", line_out, last_merged);

        // Zero byte enables, top word with upper bytes.
        issue(1'b1, 9, 0, $urandom(), 4'b0000, rand_line());
        drain("wr_be0");
        issue(1'b1, 15, 3, $urandom(), 4'b1010, rand_line());
        drain("wr_top");

        // Illegal lengths.
        issue(1'b0, 6, 0, '0, '0, rand_line());
        drain("rd_len0");
        issue(1'b0, 6, 17, '0, '0, rand_line());
        drain("rd_len17");

        // Full-line wrap.
        issue(1'b0, 15, 16, '0, '0, rand_line());
        drain("rd_full");

        // Random mix.
        for (int t = 0; t < 8; t++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, WORDS - 1), $urandom_range(1, WORDS),
                  $urandom(), 4'($urandom_range(0, 15)), rand_line());
            drain("rand");
        end

        // Reset during the second beat of an 8-beat burst, with a live handshake.
        issue(1'b0, 0, 8, '0, '0, ramp_line());
        if (BURST) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        last_merged = '0;
        @(negedge clk);
        check_val("abort_valid", rsp_valid, 1'b0);
        check_val("abort_ready", req_ready, 1'b1);
        check_val("abort_rdata", rsp_rdata, '0);
        check_val("abort_last", rsp_last, 1'b0);
        check_val("abort_line", line_out, last_merged);
        repeat (5) @(posedge clk);
        #1;

        // Recovery after the abort.
        issue(1'b0, 7, 2, '0, '0, rand_line());
        drain("recover");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
